flush_sequencer: RTL and testbench
==================================

# flush_sequencer

Parametrised flush sequencer that accepts a flush-request vector from commit/CSR logic (fence, fence.i, fence.t, sfence.vma) and drives a per-channel req/ack handshake to every flushable unit: caches, TLBs, branch predictors, LFSRs and PLRU trees. Channels marked in `AckMask` hold their request until acknowledged. All other channels get a one-cycle pulse. A timeout bounds the wait. `halt_o` stalls commit for the whole sequence, and completion is reported with a done pulse plus a sticky timeout status.

## Interface
- `NumChannels`, default 11: number of flush targets. Bit i of every vector is channel i.
- `AckMask`, default 11'h010: channels that need `flush_ack_i`. Default is dcache only.
- `TimeoutCycles`, default 1024: maximum cycles spent in WAIT. Value 0 disables the timeout.
- `CntWidth`, default max(1, $clog2(TimeoutCycles+1)): timeout counter width.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  flush request valid.
- `req_mask_i`  in  NumChannels  channels to flush. Sampled on accept.
- `req_ready_o`  out  1  sequencer can accept a request.
- `flush_req_o`  out  NumChannels  per-channel flush request, registered.
- `flush_ack_i`  in  NumChannels  per-channel acknowledge, single-cycle or level.
- `halt_o`  out  1  stall commit while a sequence is in flight.
- `done_o`  out  1  one-cycle pulse when a sequence completes.
- `timeout_o`  out  1  qualifies `done_o`: the sequence ended by timeout.
- `timeout_mask_o`  out  NumChannels  channels still pending at timeout. Held until the next accept.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Registers:
  - `pending_q`: ack channels not yet acknowledged.
  - `pulse_q`: non-ack channels, one-cycle pulse.
  - `cnt_q`: timeout counter.
  - `timeout_mask_q`.
- Ready and accept:
  - `req_ready_o` = (state==IDLE) && !rst_i.
  - Accept = `req_valid_i` && `req_ready_o`.
- On accept:
  - `pending_q` <= `req_mask_i` & `AckMask`.
  - `pulse_q` <= `req_mask_i` & ~`AckMask`.
  - `cnt_q` <= 0.
  - `timeout_mask_q` <= 0.
  - Next state is WAIT if (`req_mask_i` & `AckMask`) != 0, else DONE.
  - A zero mask is legal and goes straight to DONE.
- Request output:
  - `flush_req_o` = `pulse_q` | `pending_q`.
  - `pulse_q` clears the cycle after it is set.
  - `pending_q` is zero outside WAIT.
- WAIT:
  - `rem` = `pending_q` & ~`flush_ack_i`, then `pending_q` <= `rem`.
  - An ack on a non-pending channel is ignored.
  - If `rem` == 0, go to DONE with `timeout_o` low.
  - Else, if `TimeoutCycles` != 0 and `cnt_q` == `TimeoutCycles`-1: `timeout_mask_q` <= `rem`, `pending_q` <= 0, go to DONE with the timeout flag set.
  - Else `cnt_q` <= `cnt_q`+1. The counter never wraps.
- DONE:
  - `done_o` = 1.
  - `timeout_o` = registered timeout flag.
  - Next state is IDLE.
- `halt_o` = (state != IDLE).
- Acks in IDLE or DONE are ignored. `req_valid_i` outside IDLE is not accepted; the requester holds it.
- Simultaneous events:
  - An ack arriving on the final timeout cycle counts. If it clears the last pending bit, the sequence ends with no timeout.
  - Multiple acks in one cycle all clear.
- Reset mid-operation clears all registers asynchronously:
  - `flush_req_o` drops immediately.
  - No `done_o` is produced.

## Timing
- Reset values:
  - `req_ready_o` 0 while `rst_i` is high, 1 after release.
  - `flush_req_o` 0, `halt_o` 0, `done_o` 0, `timeout_o` 0, `timeout_mask_o` 0.
- All outputs except `req_ready_o` are functions of registered state only. No input-to-output combinational path except `rst_i` to `req_ready_o`.
- Accept in cycle t:
  - `flush_req_o` and `halt_o` assert at t+1.
  - Pulse channels are high in t+1 only.
- Non-ack-only mask: `done_o` at t+1, `req_ready_o` at t+2.
- Last ack sampled in cycle t+k (k≥1): `flush_req_o` drops and `done_o` asserts at t+k+1. Ready again at t+k+2.
- Timeout: WAIT spans t+1..t+`TimeoutCycles`, and `done_o`/`timeout_o` assert at t+`TimeoutCycles`+1.
- Back-to-back requests: the minimum spacing between accepts is 2 cycles.

## Test plan
- Non-ack-only sequence:
  - Stimulus: `req_mask_i`=11'h001, accept at t.
  - Response: `flush_req_o`=11'h001 at t+1 only; `done_o`=1 and `timeout_o`=0 at t+1; `halt_o` high for t+1 only; ready at t+2.
- Dcache with pulses:
  - Stimulus: mask 11'h01F, ack[4] at t+5.
  - Response: bits 0-3 pulse at t+1; bit 4 high t+1..t+5; `done_o` at t+6; `halt_o` high t+1..t+6.
- Timeout:
  - Stimulus: `TimeoutCycles`=4, `AckMask`=11'h030, mask 11'h030, only ack[5] at t+2.
  - Response: `done_o`=`timeout_o`=1 at t+5; `timeout_mask_o`=11'h010, held until the next accept.
- Last-cycle ack:
  - Stimulus: as the timeout case, but ack[4] at t+4.
  - Response: `done_o` at t+5 with `timeout_o`=0.
- Reset mid-WAIT:
  - Stimulus: assert `rst_i` at t+3.
  - Response: `flush_req_o`, `halt_o`, `req_ready_o`=0 immediately; no `done_o`; after release a new request is accepted.
- Spurious acks and zero mask:
  - Stimulus: acks in IDLE; mask 0 accepted.
  - Response: acks have no effect; the zero mask gives `done_o` at t+1 with `flush_req_o`=0 throughout.

Source files
------------

// File: rtl/flush_sequencer.sv
// Flush sequencer: fans a flush-request vector out to per-unit req/ack channels,
// holding ack channels until acknowledged or timed out, pulsing the rest.
module flush_sequencer #(
    parameter int                     NumChannels   = 11,
    parameter logic [NumChannels-1:0] AckMask       = 11'h010,
    parameter int                     TimeoutCycles = 1024,
    parameter int                     CntWidth      =
        ($clog2(TimeoutCycles + 1) < 1) ? 1 : $clog2(TimeoutCycles + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic [NumChannels-1:0] req_mask_i,
    output logic                   req_ready_o,
    output logic [NumChannels-1:0] flush_req_o,
    input  logic [NumChannels-1:0] flush_ack_i,
    output logic                   halt_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [NumChannels-1:0] timeout_mask_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam bit TimeoutEn = (TimeoutCycles != 0);
    localparam logic [CntWidth-1:0] CntLast =
        CntWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);
    localparam logic [CntWidth-1:0] CntMax = '1;

    state_e                 state_q;
    logic [NumChannels-1:0] pending_q;
    logic [NumChannels-1:0] pulse_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [NumChannels-1:0] timeout_mask_q;
    logic                   timeout_q;

    logic                   accept;
    logic [NumChannels-1:0] ack_req;
    logic [NumChannels-1:0] pending_d;

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;
    assign ack_req     = req_mask_i & AckMask;

    // Acks on channels that are not pending simply fall out of the AND.
    assign pending_d   = pending_q & ~flush_ack_i;

    assign flush_req_o    = pulse_q | pending_q;
    assign halt_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign timeout_o      = timeout_q;
    assign timeout_mask_o = timeout_mask_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            pending_q      <= '0;
            pulse_q        <= '0;
            cnt_q          <= '0;
            timeout_mask_q <= '0;
            timeout_q      <= 1'b0;
        end else begin
            pulse_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        pending_q      <= ack_req;
                        pulse_q        <= req_mask_i & ~AckMask;
                        cnt_q          <= '0;
                        timeout_mask_q <= '0;
                        timeout_q      <= 1'b0;
                        state_q        <= (|ack_req) ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    pending_q <= pending_d;
                    if (pending_d == '0) begin
                        timeout_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (TimeoutEn && (cnt_q == CntLast)) begin
                        // An ack landing on this last cycle is already folded into pending_d.
                        timeout_mask_q <= pending_d;
                        pending_q      <= '0;
                        timeout_q      <= 1'b1;
                        state_q        <= DONE;
                    end else if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    timeout_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flush_sequencer.sv
// Testbench for flush_sequencer: default instance plus a short-timeout,
// two-ack-channel instance; completions are scored against a queue.
module tb_flush_sequencer;

    localparam int N = 11;

    typedef struct {
        int           cyc;
        logic         to;
        logic [N-1:0] tm;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [1:0]   rst;
    logic [1:0]   valid;
    logic [N-1:0] mask  [2];
    logic [N-1:0] ack   [2];
    logic [1:0]   ready;
    logic [1:0]   halt;
    logic [1:0]   done;
    logic [1:0]   tout;
    logic [N-1:0] freq  [2];
    logic [N-1:0] tmask [2];

    exp_t q0[$];
    exp_t q1[$];

    flush_sequencer u_def (
        .clk_i          (clk),
        .rst_i          (rst[0]),
        .req_valid_i    (valid[0]),
        .req_mask_i     (mask[0]),
        .req_ready_o    (ready[0]),
        .flush_req_o    (freq[0]),
        .flush_ack_i    (ack[0]),
        .halt_o         (halt[0]),
        .done_o         (done[0]),
        .timeout_o      (tout[0]),
        .timeout_mask_o (tmask[0])
    );

    flush_sequencer #(
        .NumChannels   (N),
        .AckMask       (11'h030),
        .TimeoutCycles (4)
    ) u_to (
        .clk_i          (clk),
        .rst_i          (rst[1]),
        .req_valid_i    (valid[1]),
        .req_mask_i     (mask[1]),
        .req_ready_o    (ready[1]),
        .flush_req_o    (freq[1]),
        .flush_ack_i    (ack[1]),
        .halt_o         (halt[1]),
        .done_o         (done[1]),
        .timeout_o      (tout[1]),
        .timeout_mask_o (tmask[1])
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic score(int d);
        exp_t e;
        if (d == 0) begin
            if (q0.size() == 0) begin
                check("unexpected_done0", 1, 0);
                return;
            end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin
                check("unexpected_done1", 1, 0);
                return;
            end
            e = q1.pop_front();
        end
        check("done_cycle", cyc, e.cyc);
        check("done_timeout", 32'(tout[d]), 32'(e.to));
        check("done_tmask", 32'(tmask[d]), 32'(e.tm));
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++)
            if (done[d] === 1'b1) score(d);
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Drive a request in the current cycle t; returns in cycle t+1.
    task automatic accept(int d, logic [N-1:0] m, int lat, logic to, logic [N-1:0] tm);
        exp_t e;
        e.cyc = cyc + lat;
        e.to  = to;
        e.tm  = tm;
        check("ready_before_accept", 32'(ready[d]), 1);
        valid[d] = 1'b1;
        mask[d]  = m;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        step();
        valid[d] = 1'b0;
        mask[d]  = '0;
    endtask

    initial begin
        rst   = 2'b11;
        valid = 2'b00;
        mask  = '{default: '0};
        ack   = '{default: '0};
        repeat (2) step();
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ready[d]), 0);
            check("rst_freq", 32'(freq[d]), 0);
            check("rst_halt", 32'(halt[d]), 0);
            check("rst_done", 32'(done[d]), 0);
            check("rst_tout", 32'(tout[d]), 0);
            check("rst_tmask", 32'(tmask[d]), 0);
        end
        rst = 2'b00;
        step();
        check("ready_after_rst0", 32'(ready[0]), 1);
        check("ready_after_rst1", 32'(ready[1]), 1);

        // Pulse-only channel
        accept(0, 11'h001, 1, 1'b0, '0);
        check("p_freq", 32'(freq[0]), 32'h001);
        check("p_halt", 32'(halt[0]), 1);
        check("p_ready", 32'(ready[0]), 0);
        step();
        check("p_freq_end", 32'(freq[0]), 0);
        check("p_halt_end", 32'(halt[0]), 0);
        check("p_ready_end", 32'(ready[0]), 1);

        // Dcache plus pulses, ack at t+5
        accept(0, 11'h01F, 6, 1'b0, '0);
        check("d_freq_t1", 32'(freq[0]), 32'h01F);
        check("d_halt_t1", 32'(halt[0]), 1);
        for (int k = 2; k <= 5; k++) begin
            step();
            check("d_freq_hold", 32'(freq[0]), 32'h010);
            check("d_halt_hold", 32'(halt[0]), 1);
        end
        ack[0] = 11'h010;
        step();
        ack[0] = '0;
        check("d_freq_t6", 32'(freq[0]), 0);
        check("d_halt_t6", 32'(halt[0]), 1);
        step();
        check("d_halt_t7", 32'(halt[0]), 0);
        check("d_ready_t7", 32'(ready[0]), 1);

        // Timeout with one of two ack channels answered
        accept(1, 11'h030, 5, 1'b1, 11'h010);
        check("to_freq_t1", 32'(freq[1]), 32'h030);
        step();
        ack[1] = 11'h020;
        step();
        ack[1] = '0;
        check("to_freq_t3", 32'(freq[1]), 32'h010);
        step();
        check("to_freq_t4", 32'(freq[1]), 32'h010);
        step();
        check("to_freq_t5", 32'(freq[1]), 0);
        check("to_halt_t5", 32'(halt[1]), 1);
        step();
        check("to_halt_t6", 32'(halt[1]), 0);
        check("to_tout_t6", 32'(tout[1]), 0);
        repeat (3) step();
        check("to_tmask_held", 32'(tmask[1]), 32'h010);

        // Last remaining ack on the final timeout cycle
        accept(1, 11'h030, 5, 1'b0, '0);
        check("lc_tmask_clr", 32'(tmask[1]), 0);
        step();
        ack[1] = 11'h020;
        step();
        ack[1] = '0;
        step();
        ack[1] = 11'h010;
        step();
        ack[1] = '0;
        step();
        step();
        check("lc_ready", 32'(ready[1]), 1);

        // Both ack channels in one cycle
        accept(1, 11'h030, 2, 1'b0, '0);
        ack[1] = 11'h030;
        step();
        ack[1] = '0;
        check("ma_freq", 32'(freq[1]), 0);
        step();
        check("ma_ready", 32'(ready[1]), 1);

        // Full-length default timeout
        accept(0, 11'h010, 1025, 1'b1, 11'h010);
        repeat (1030) step();
        check("dto_tmask", 32'(tmask[0]), 32'h010);

        // Reset mid-WAIT
        accept(0, 11'h010, 100, 1'b0, '0);
        step();
        step();
        rst[0] = 1'b1;
        #1;
        check("mr_freq", 32'(freq[0]), 0);
        check("mr_halt", 32'(halt[0]), 0);
        check("mr_ready", 32'(ready[0]), 0);
        check("mr_tmask", 32'(tmask[0]), 0);
        q0.delete();
        step();
        step();
        rst[0] = 1'b0;
        step();
        accept(0, 11'h001, 1, 1'b0, '0);
        check("mr_new_freq", 32'(freq[0]), 32'h001);
        step();

        // Spurious acks in IDLE, then a zero mask
        for (int k = 0; k < 3; k++) begin
            ack[0] = '1;
            step();
            check("sp_freq", 32'(freq[0]), 0);
            check("sp_halt", 32'(halt[0]), 0);
            check("sp_ready", 32'(ready[0]), 1);
        end
        ack[0] = '0;
        accept(0, '0, 1, 1'b0, '0);
        check("z_freq", 32'(freq[0]), 0);
        check("z_halt", 32'(halt[0]), 1);
        step();
        check("z_freq_end", 32'(freq[0]), 0);
        check("z_ready", 32'(ready[0]), 1);

        for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) step();
        check("pending_completions", q0.size() + q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
